// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding and
// the default operand/result width of the shared `multu` instance.
package mult_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

endpackage : mult_arbiter_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or
// above the pointer, searching upward with wraparound.
// Ports:
//   req         in   NUM_REQ  request vector
//   ptr         in   IDX_W    highest-priority index (must be < NUM_REQ)
//   gnt_valid_c out  1        any request granted
//   gnt_oh_c    out  NUM_REQ  one-hot grant
//   gnt_idx_c   out  IDX_W    binary grant index
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               gnt_valid_c,
  output logic [NUM_REQ-1:0] gnt_oh_c,
  output logic [IDX_W-1:0]   gnt_idx_c
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [IDX_W:0] cand;

  // Scan NUM_REQ candidates starting at ptr; first hit wins.
  always_comb begin
    gnt_valid_c = 1'b0;
    gnt_oh_c    = '0;
    gnt_idx_c   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!gnt_valid_c && req[cand[IDX_W-1:0]]) begin
        gnt_valid_c                = 1'b1;
        gnt_idx_c                  = cand[IDX_W-1:0];
        gnt_oh_c[cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/mult_arbiter.sv
// Shares one iterative unsigned multiplier (`multu`) among NUM_REQ
// requesters: round-robin grant, operand capture, one-cycle doMult launch,
// completion detection on a level done signal, and result return.
// Optional watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
// Ports:
//   clk, reset  in   clock (rising edge), async active-high reset
//   req_valid   in   NUM_REQ        per-requester request, held until response
//   req_a/req_b in   NUM_REQ*WIDTH  packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid  out  NUM_REQ        one-cycle completion pulse
//   resp_data   out  WIDTH          product, holds between responses
//   resp_err    out  1              timeout flag, qualified by resp_valid
//   busy        out  1              grant through response cycle
//   m_a/m_b     out  WIDTH          multiplier operands
//   m_doMult    out  1              multiplier launch pulse
//   m_out       in   WIDTH          multiplier result
//   m_done      in   1              multiplier done level
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned WIDTH          = DEFAULT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     resp_err,
  output logic                     busy,
  output logic [WIDTH-1:0]         m_a,
  output logic [WIDTH-1:0]         m_b,
  output logic                     m_doMult,
  input  logic [WIDTH-1:0]         m_out,
  input  logic                     m_done
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [NUM_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic               armed_q, armed_d;
  logic [WIDTH-1:0]   m_a_d, m_b_d, resp_data_d;
  logic               do_mult_d, busy_d;
  logic [NUM_REQ-1:0] resp_valid_d;

  logic               gnt_valid_c;
  logic [NUM_REQ-1:0] gnt_oh_c;
  logic [IDX_W-1:0]   gnt_idx_c;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            resp_err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign resp_err           = 1'b0;
`endif

  // Unpack operand buses so the granted requester can be selected by index.
  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req         (req_valid),
    .ptr         (ptr_q),
    .gnt_valid_c (gnt_valid_c),
    .gnt_oh_c    (gnt_oh_c),
    .gnt_idx_c   (gnt_idx_c)
  );

  // State register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      gnt_oh_q   <= '0;
      armed_q    <= 1'b0;
      m_a        <= '0;
      m_b        <= '0;
      m_doMult   <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= '0;
      resp_data  <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      to_cnt_q   <= '0;
      resp_err   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_oh_q   <= gnt_oh_d;
      armed_q    <= armed_d;
      m_a        <= m_a_d;
      m_b        <= m_b_d;
      m_doMult   <= do_mult_d;
      busy       <= busy_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
`ifdef MULT_ARB_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      resp_err   <= resp_err_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_oh_d     = gnt_oh_q;
    armed_d      = armed_q;
    m_a_d        = m_a;
    m_b_d        = m_b;
    do_mult_d    = 1'b0;
    busy_d       = busy;
    resp_valid_d = '0;
    resp_data_d  = resp_data;
`ifdef MULT_ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    resp_err_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_c) begin
          gnt_idx_d = gnt_idx_c;
          gnt_oh_d  = gnt_oh_c;
          m_a_d     = a_arr[gnt_idx_c];
          m_b_d     = b_arr[gnt_idx_c];
          busy_d    = 1'b1;
          do_mult_d = 1'b1;
          state_d   = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        armed_d = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
        to_cnt_d = '0;
`endif
        state_d = ST_WAIT;
      end

      // Done is only trusted after it has been seen low once, so a done
      // level left over from the previous operation is not mistaken for ours.
      ST_WAIT: begin
        if (m_done && armed_q) begin
          resp_data_d  = m_out;
          resp_valid_d = gnt_oh_q;
          state_d      = ST_RESP;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = gnt_oh_q;
          state_d      = ST_RESP;
        end
`endif
        else begin
          if (!m_done) begin
            armed_d = 1'b1;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          to_cnt_d = to_cnt_q + TO_W'(1);
`endif
        end
      end

      ST_RESP: begin
        ptr_d   = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule : mult_arbiter

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed requests with hand-computed
// products, a behavioural multu stand-in, and a scoreboard monitor.
module tb_mult_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*W-1:0] req_a = '0;
  logic [NR*W-1:0] req_b = '0;
  logic [NR-1:0]   resp_valid;
  logic [W-1:0]    resp_data;
  logic            resp_err;
  logic            busy;
  logic [W-1:0]    m_a, m_b;
  logic            m_doMult;
  logic [W-1:0]    m_out;
  logic            m_done;

  int n_checks = 0;
  int n_pass   = 0;

  mult_arbiter #(
    .NUM_REQ        (NR),
    .WIDTH          (W),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy),
    .m_a        (m_a),
    .m_b        (m_b),
    .m_doMult   (m_doMult),
    .m_out      (m_out),
    .m_done     (m_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    else n_pass++;
  endtask

  // multu stand-in: optional stale-done period, then low for mul_lat-1
  // cycles, then done high (held) with the product.
  int stale_hold = 0;
  int mul_lat    = 3;
  bit hang       = 0;
  logic [W-1:0] ra, rb;
  int  cnt;
  bit  active;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_done <= 1'b0;
      m_out  <= '0;
      active <= 1'b0;
      cnt    <= 0;
    end else if (m_doMult) begin
      ra     <= m_a;
      rb     <= m_b;
      cnt    <= stale_hold + mul_lat;
      active <= !hang;
      if (stale_hold == 0 || hang) m_done <= 1'b0;
    end else if (active) begin
      if (cnt == mul_lat) m_done <= 1'b0;
      if (cnt == 1) begin
        m_done <= 1'b1;
        m_out  <= ra * rb;
        active <= 1'b0;
        chk("op_hold_a", 64'(m_a), 64'(ra));
        chk("op_hold_b", 64'(m_b), 64'(rb));
      end
      cnt <= cnt - 1;
    end
  end

  // Scoreboard.
  typedef struct {
    int          idx;
    logic [W-1:0] data;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input int idx, input logic [W-1:0] data, input logic err);
    exp_t e;
    e.idx = idx; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  int pulses = 0;
  bit chk_idle = 0;
  always @(negedge clk) begin
    exp_t e;
    logic [NR-1:0] oh;
    if (reset) begin
      pulses   = 0;
      chk_idle = 0;
    end else begin
      if (chk_idle) begin
        chk("busy_after_resp", 64'(busy), 64'd0);
        chk_idle = 0;
      end
      if (m_doMult) pulses++;
      if (resp_valid != '0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_resp got=%b exp=none", resp_valid);
        end else begin
          e  = exp_q.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          chk("resp_onehot", 64'(resp_valid), 64'(oh));
          chk("resp_data",   64'(resp_data),  64'(e.data));
          chk("resp_err",    64'(resp_err),   64'(e.err));
          chk("busy_in_resp", 64'(busy), 64'd1);
          chk("domult_pulses", 64'(pulses), 64'd1);
        end
        pulses   = 0;
        chk_idle = 1;
      end
    end
  end

  task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_valid[idx]    = 1'b1;
  endtask

  task automatic wait_resp(input int idx);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_valid[idx]) begin
        req_valid[idx] = 1'b0;
        return;
      end
    end
    n_checks++;
    $display("FAIL wait_resp%0d got=no_response exp=response", idx);
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_dm();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_doMult) return;
    end
    n_checks++;
    $display("FAIL wait_domult got=no_pulse exp=pulse");
  endtask

  task automatic do_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    set_req(idx, a, b);
    wait_resp(idx);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data",  64'(resp_data),  64'd0);
    chk("rst_resp_err",   64'(resp_err),   64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_m_a",        64'(m_a),        64'd0);
    chk("rst_m_b",        64'(m_b),        64'd0);
    chk("rst_m_domult",   64'(m_doMult),   64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single requester 0.
    push_exp(0, 32'd10, 1'b0);
    do_req(0, 32'd2, 32'd5);
    @(negedge clk);

    // Requester 2, operand changed after grant.
    push_exp(2, 32'h0000_013B, 1'b0);
    set_req(2, 32'h03, 32'h69);
    wait_dm();
    req_a[2*W +: W] = 32'h55;
    wait_resp(2);
    @(negedge clk);

    // Truncation cases.
    push_exp(1, 32'hFFFF_FFFE, 1'b0);
    do_req(1, 32'hFFFF_FFFF, 32'h2);
    push_exp(3, 32'h0000_0001, 1'b0);
    do_req(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);

    // All four at once, pointer back at 0; requester 0 re-requests.
    push_exp(0, 32'd12, 1'b0);
    push_exp(1, 32'd30, 1'b0);
    push_exp(2, 32'd56, 1'b0);
    push_exp(3, 32'd90, 1'b0);
    push_exp(0, 32'd132, 1'b0);
    fork
      begin do_req(0, 32'd3, 32'd4); do_req(0, 32'd11, 32'd12); end
      do_req(1, 32'd5, 32'd6);
      do_req(2, 32'd7, 32'd8);
      do_req(3, 32'd9, 32'd10);
    join
    @(negedge clk);

    // Stale done level held over from previous operation.
    stale_hold = 3;
    push_exp(1, 32'd42, 1'b0);
    do_req(1, 32'd6, 32'd7);
    stale_hold = 0;
    @(negedge clk);

    // Reset during WAIT aborts with no response; request re-served after.
    mul_lat = 10;
    set_req(3, 32'd4, 32'd4);
    wait_dm();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    chk("abort_resp_data",  64'(resp_data),  64'd0);
    chk("abort_busy",       64'(busy),       64'd0);
    chk("abort_m_a",        64'(m_a),        64'd0);
    chk("abort_m_b",        64'(m_b),        64'd0);
    chk("abort_m_domult",   64'(m_doMult),   64'd0);
    mul_lat = 3;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_exp(3, 32'd16, 1'b0);
    wait_resp(3);
    @(negedge clk);

`ifdef MULT_ARB_TIMEOUT_EN
    // Watchdog: done never rises; 8 WAIT cycles then error response.
    begin
      int n;
      hang = 1;
      push_exp(2, 32'd0, 1'b1);
      set_req(2, 32'd5, 32'd5);
      wait_dm();
      n = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        n++;
        if (resp_valid[2]) break;
      end
      req_valid[2] = 1'b0;
      chk("timeout_latency", 64'(n), 64'd9);
      hang = 0;
      @(negedge clk);
      // Pointer advanced to 3, so requester 3 wins over 2.
      push_exp(3, 32'd6, 1'b0);
      push_exp(2, 32'd20, 1'b0);
      fork
        do_req(2, 32'd4, 32'd5);
        do_req(3, 32'd2, 32'd3);
      join
      @(negedge clk);
    end
`endif

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mult_arbiter

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one iterative unsigned multiplier (`multu`) between NUM_REQ requesters.
- Round-robin arbitration, operand capture, `doMult` launch pulse, completion detection on `mult_done`, and result return to the granted requester.
- Sits between requesting datapath units and the single `multu` instance; `multu` ports connect 1:1 to the `m_*` ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width; must match `multu`
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with MULT_ARB_TIMEOUT_EN

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request; held high with operands stable until that requester's resp_valid
- req_a  in  NUM_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing
- resp_valid  out  NUM_REQ  one-cycle completion pulse to requester i
- resp_data  out  WIDTH  product (`multu` `out`), valid while any resp_valid bit is high
- resp_err  out  1  timeout flag, qualified by resp_valid
- busy  out  1  high from grant until the response cycle inclusive
- m_a  out  WIDTH  to `multu` a
- m_b  out  WIDTH  to `multu` b
- m_doMult  out  1  to `multu` doMult; one-cycle pulse
- m_out  in  WIDTH  from `multu` out
- m_done  in  1  from `multu` mult_done; level signal

Behaviour:
- Reset value of every output and internal register is 0:
  - resp_valid, resp_data, resp_err, busy, m_a, m_b, m_doMult all 0.
  - RR pointer = 0.
  - State = IDLE.
- Reset asserted mid-operation aborts immediately:
  - No response is issued.
  - The requester keeps req_valid and is re-arbitrated after reset.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If any req_valid, grant the first set bit at or after the RR pointer, searching upward with wrap.
  - Latch the granted index and that requester's req_a/req_b into the m_a/m_b registers.
  - busy <= 1; go to LAUNCH.
- LAUNCH:
  - m_doMult = 1 for exactly this cycle; the armed flag is cleared.
  - Go to WAIT.
- WAIT:
  - m_doMult = 0.
  - armed flag <= 1 the first cycle m_done is sampled low.
  - m_done high while armed: capture m_out into resp_data and go to RESP.
  - m_done high while not armed is ignored; this covers a stale done level left from the previous operation.
- RESP:
  - resp_valid[granted] = 1 for one cycle; busy stays 1.
  - RR pointer <= granted+1, mod NUM_REQ.
  - Next state IDLE; busy <= 0.
- m_a/m_b hold their values from grant through RESP; requester operand changes after grant have no effect.
- Minimum grant-to-response latency is 3 cycles plus the multiplier time. There is no fixed upper bound without the timeout.
- At most one operation in flight; no back-to-back overlap.
- A new grant can be issued in the cycle after RESP.
- Requests arriving during busy wait; no request is lost.
- A requester that drops req_valid while not granted is simply skipped.
- resp_data is the low WIDTH bits of the product, exactly as `multu` returns; no width extension or overflow flag.
- resp_data holds its last value between responses; resp_err is 0 whenever resp_valid is 0.

Optional Feature:
- Macro MULT_ARB_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 on entry to WAIT.
  - When the counter reaches TIMEOUT_CYCLES without an armed m_done, go to RESP with resp_err=1 and resp_data=0.
  - The RR pointer still advances.
- Undefined: no counter; WAIT waits indefinitely; resp_err is tied to 0.

Decomposition:
- Shared package: FSM state encoding (2-bit IDLE/LAUNCH/WAIT/RESP) and default WIDTH constant.
- Sub-module: rr_arbiter. Combinational grant from req_valid and pointer, returning a one-hot and an index. Reusable by other shared-resource controllers.

Test Plan:
- Single requester 0, A=2, B=5 -> exactly one m_doMult pulse; resp_valid[0] one cycle; resp_data=10; busy low the cycle after.
- Requester 2, A=0x03, B=0x69 -> resp_valid[2], resp_data=0x13B; m_a/m_b stable through WAIT even when req_a changes after grant.
- A=0xFFFFFFFF, B=0x2 -> resp_data=0xFFFFFFFE. Then A=B=0xFFFFFFFF -> resp_data=0x00000001.
- All four requesters assert in the same cycle, pointer=0 -> grants in order 0,1,2,3; requester 0 re-requesting immediately is served after 3.
- m_done held high from the previous operation at LAUNCH -> not accepted until it drops and rises again. Reset asserted in WAIT -> all outputs 0 the same cycle, no resp_valid.
- MULT_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, m_done held low -> resp_valid with resp_err=1 and resp_data=0 after 8 WAIT cycles; RR pointer advances.
